gf180mcu_fd_sc_mcu9t5v0__dlyline: RTL

//  - Clocked, parametrised successor to the fixed analogue delay buffers: a WIDTH-bit delay line.
//  - Delay is selectable at run time, from 0 to DEPTH clock cycles.
//  - Each data sample carries a valid flag. After a delay change, the block blanks its output

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__dlyline_pkg.sv | 15 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__dlyline_stage.sv | 51 +++++
 rtl/gf180mcu_fd_sc_mcu9t5v0__dlyline.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyline_pkg.sv
// Shared types and helpers for the clocked delay line.
// Optional feature macro: GF180MCU_FD_SC_MCU9T5V0__DLYLINE_PARITY_EN
package gf180mcu_fd_sc_mcu9t5v0__dlyline_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SETTLE = 1'b1
    } dly_state_t;

    // Requested delays beyond the physical stage count map onto the last stage.
    function automatic int clamp_sel(input int sel, input int depth);
        return (sel > depth) ? depth : sel;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyline_stage.sv
// One register stage of the delay line: {valid, [parity,] data}.
// Optional feature macro: GF180MCU_FD_SC_MCU9T5V0__DLYLINE_PARITY_EN adds a stored parity bit.
module gf180mcu_fd_sc_mcu9t5v0__dlyline_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rn_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
`ifdef GF180MCU_FD_SC_MCU9T5V0__DLYLINE_PARITY_EN
    input  logic             parity_i,
    output logic             parity_o,
`endif
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Capture the upstream sample whenever the line advances; otherwise hold.
    always_ff @(posedge clk_i or negedge rn_i) begin
        if (!rn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

`ifdef GF180MCU_FD_SC_MCU9T5V0__DLYLINE_PARITY_EN
    logic parity_q;

    // Parity travels alongside its data word so corruption can be detected at the tap.
    always_ff @(posedge clk_i or negedge rn_i) begin
        if (!rn_i) begin
            parity_q <= 1'b0;
        end else if (en_i) begin
            parity_q <= parity_i;
        end
    end

    assign parity_o = parity_q;
`endif

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyline.sv
// Run-time selectable WIDTH-bit delay line (0..DEPTH cycles) with valid tracking and
// output blanking while a newly selected delay fills up.
// Optional feature macro: GF180MCU_FD_SC_MCU9T5V0__DLYLINE_PARITY_EN adds the PERR output.
module gf180mcu_fd_sc_mcu9t5v0__dlyline
    import gf180mcu_fd_sc_mcu9t5v0__dlyline_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int SELW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic [WIDTH-1:0] I,
    input  logic             IV,
    input  logic [SELW-1:0]  SEL,
`ifdef GF180MCU_FD_SC_MCU9T5V0__DLYLINE_PARITY_EN
    output logic             PERR,
`endif
    output logic [WIDTH-1:0] Z,
    output logic             ZV,
    output logic             BUSY
);

    logic [WIDTH-1:0] stageData  [DEPTH];
    logic             stageValid [DEPTH];
`ifdef GF180MCU_FD_SC_MCU9T5V0__DLYLINE_PARITY_EN
    logic             stagePar   [DEPTH];
`endif

    logic [SELW-1:0] selClamp;
    logic [SELW-1:0] sel_q, sel_d;
    logic [SELW-1:0] cnt_q, cnt_d;
    dly_state_t      state_q, state_d;

    assign selClamp = SELW'(clamp_sel(int'(SEL), DEPTH));

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] dIn;
        logic             vIn;
        if (k == 0) begin : g_head
            assign dIn = I;
            assign vIn = IV;
        end else begin : g_tail
            assign dIn = stageData[k-1];
            assign vIn = stageValid[k-1];
        end
`ifdef GF180MCU_FD_SC_MCU9T5V0__DLYLINE_PARITY_EN
        logic pIn;
        if (k == 0) begin : g_phead
            assign pIn = ^I;
        end else begin : g_ptail
            assign pIn = stagePar[k-1];
        end
`endif
        gf180mcu_fd_sc_mcu9t5v0__dlyline_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i    (CLK),
            .rn_i     (RN),
            .en_i     (EN),
            .valid_i  (vIn),
            .data_i   (dIn),
`ifdef GF180MCU_FD_SC_MCU9T5V0__DLYLINE_PARITY_EN
            .parity_i (pIn),
            .parity_o (stagePar[k]),
`endif
            .valid_o  (stageValid[k]),
            .data_o   (stageData[k])
        );
    end

    // Next-state: a new non-zero delay starts a settle window that lasts as many EN
    // cycles as the delay, so only samples taken after the change become valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if (EN) begin
            sel_d = selClamp;
            if (selClamp != sel_q) begin
                if (selClamp == '0) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    state_d = SETTLE;
                    cnt_d   = selClamp - SELW'(1);
                end
            end else if (state_q == SETTLE) begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - SELW'(1);
                end
            end
        end
    end

    // Control registers; EN low holds them because the next-state logic keeps them.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= RUN;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    assign BUSY = (state_q == SETTLE);

    // Output tap: delay 0 is a combinational bypass, delay N taps stage N-1.
    always_comb begin
        Z  = I;
        ZV = IV;
`ifdef GF180MCU_FD_SC_MCU9T5V0__DLYLINE_PARITY_EN
        PERR = 1'b0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (sel_q == SELW'(k + 1)) begin
                Z  = stageData[k];
                ZV = stageValid[k] & (state_q == RUN);
`ifdef GF180MCU_FD_SC_MCU9T5V0__DLYLINE_PARITY_EN
                PERR = stageValid[k] & (state_q == RUN) & ((^stageData[k]) != stagePar[k]);
`endif
            end
        end
    end

endmodule
